// File: rtl/ad_pack_pkg.sv
// Shared constants, FSM state type and data-word formatting for the ADC frame packer.
package ad_pack_pkg;

    localparam int FRAME_WORDS = 5;
    localparam int CH_NUM      = 4;
    localparam logic [5:0] DATA_TAG = 6'b110000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        TRAIL   = 2'd2,
        DISCARD = 2'd3
    } state_e;

    function automatic logic [31:0] make_data_word(input logic [1:0] ch, input logic [11:0] sample);
        return {DATA_TAG, ch, 12'h000, sample};
    endfunction

endpackage

// File: rtl/ad_frame_fifo.sv
// Single-clock RAM FIFO with a speculative write pointer that is either committed
// (frame becomes visible) or rolled back; first-word-fall-through registered output.
module ad_frame_fifo #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [31:0]   wr_data,
    input  logic          commit,
    input  logic          rollback,
    input  logic          rd_en,
    output logic [AW:0]   free_cnt,
    output logic [31:0]   out_data,
    output logic          out_valid
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};

    logic [31:0] mem_q [DEPTH];

    logic [AW:0] spec_q, spec_d;
    logic [AW:0] commit_q, commit_d;
    logic [AW:0] rd_q, rd_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] rd_word;
    logic        wr_fire;

    assign wr_fire  = wr_en & ~rollback;
    assign free_cnt = DEPTH_W - (spec_q - rd_q);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    // Pointer updates and next output word; a word written this cycle at the next
    // read address is forwarded so a trailer can follow D3 without a bubble.
    always_comb begin
        spec_d      = spec_q;
        commit_d    = commit_q;
        rd_d        = rd_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        rd_word     = 32'h0000_0000;

        if (rollback) begin
            spec_d = commit_q;
        end else if (wr_en) begin
            spec_d = spec_q + {{AW{1'b0}}, 1'b1};
        end else begin
            spec_d = spec_q;
        end

        if (commit) begin
            commit_d = spec_d;
        end else begin
            commit_d = commit_q;
        end

        if (rd_en && out_valid_q) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_d = rd_q;
        end

        if (wr_fire && (spec_q == rd_d)) begin
            rd_word = wr_data;
        end else begin
            rd_word = mem_q[rd_d[AW-1:0]];
        end

        out_valid_d = (commit_d != rd_d);
        if (out_valid_d) begin
            out_data_d = rd_word;
        end else begin
            out_data_d = out_data_q;
        end
    end

    // Storage array; no reset needed since pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[spec_q[AW-1:0]] <= wr_data;
        end
    end

    // Pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_q      <= '0;
            commit_q    <= '0;
            rd_q        <= '0;
            out_data_q  <= 32'h0000_0000;
            out_valid_q <= 1'b0;
        end else begin
            spec_q      <= spec_d;
            commit_q    <= commit_d;
            rd_q        <= rd_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: rtl/ad_frame_packer.sv
// ADC burst-to-frame packer: tags 4 samples, appends a trailer and releases whole frames.
// Optional feature macro: CHECKSUM_EN (trailer carries a 16-bit sample sum).
module ad_frame_packer
    import ad_pack_pkg::*;
#(
    parameter int          FIFO_AW   = 5,
    parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_err,
    output logic [15:0] drop_cnt
);

    localparam logic [FIFO_AW:0] FRAME_W = (FIFO_AW+1)'(FRAME_WORDS);

    state_e      state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic [15:0] seq_q, seq_d;
    logic [15:0] frame_seq_q, frame_seq_d;
    logic [15:0] drop_q, drop_d;
    logic        err_q, err_d;
    logic        drop_inc;

    logic             fifo_wr;
    logic [31:0]      fifo_wdata;
    logic             fifo_commit;
    logic             fifo_rollback;
    logic [FIFO_AW:0] fifo_free;

    logic [11:0] sample;
    logic [31:0] trailer;
    logic        unused_bits;

    assign sample = in_data[11:0];

`ifdef CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    assign trailer     = {SYNC_WORD[15:8], frame_seq_q[7:0], csum_q};
    assign unused_bits = ^{in_data[31:12], frame_seq_q[15:8]};
`else
    assign trailer     = {SYNC_WORD, frame_seq_q};
    assign unused_bits = ^in_data[31:12];
`endif

    // Frame FSM: burst admission, speculative writes, trailer commit and error handling.
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        seq_d         = seq_q;
        frame_seq_d   = frame_seq_q;
        err_d         = 1'b0;
        drop_inc      = 1'b0;
        fifo_wr       = 1'b0;
        fifo_wdata    = make_data_word(ch_q, sample);
        fifo_commit   = 1'b0;
        fifo_rollback = 1'b0;
`ifdef CHECKSUM_EN
        csum_d        = csum_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    seq_d       = seq_q + 16'd1;
                    frame_seq_d = seq_q;
                    if (fifo_free >= FRAME_W) begin
                        fifo_wr = 1'b1;
                        ch_d    = ch_q + 2'd1;
`ifdef CHECKSUM_EN
                        csum_d  = {4'h0, sample};
`endif
                        state_d = COLLECT;
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = DISCARD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    fifo_wr = 1'b1;
                    ch_d    = ch_q + 2'd1;
`ifdef CHECKSUM_EN
                    csum_d  = csum_q + {4'h0, sample};
`endif
                    if (ch_q == 2'd3) begin
                        state_d = TRAIL;
                    end else begin
                        state_d = COLLECT;
                    end
                end else begin
                    fifo_rollback = 1'b1;
                    ch_d          = 2'd0;
                    err_d         = 1'b1;
                    drop_inc      = 1'b1;
                    state_d       = IDLE;
                end
            end
            TRAIL: begin
                fifo_wr     = 1'b1;
                fifo_wdata  = trailer;
                fifo_commit = 1'b1;
                // A fifth word means the burst overran; the frame is still good.
                if (in_valid) begin
                    err_d   = 1'b1;
                    state_d = DISCARD;
                end else begin
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if (!in_valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = DISCARD;
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = 2'd0;
            end
        endcase

        if (drop_inc && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= 2'd0;
            seq_q       <= 16'h0000;
            frame_seq_q <= 16'h0000;
            drop_q      <= 16'h0000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            seq_q       <= seq_d;
            frame_seq_q <= frame_seq_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
        end
    end

`ifdef CHECKSUM_EN
    // Running sample sum for the trailer.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= 16'h0000;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    ad_frame_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (fifo_wr),
        .wr_data   (fifo_wdata),
        .commit    (fifo_commit),
        .rollback  (fifo_rollback),
        .rd_en     (out_ready),
        .free_cnt  (fifo_free),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    assign frame_err = err_q;
    assign drop_cnt  = drop_q;

endmodule
